// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - shared defaults, stage record type and helpers for the PC pipeline
package pc_pkg;

  localparam int unsigned XLEN_DEF  = 32;
  localparam int unsigned INCR_DEF  = 4;
  localparam int unsigned CNT_W_DEF = 32;
  localparam logic [XLEN_DEF-1:0] PC_RESET_VECTOR = '0;

  // One delay-stage record at the default PC width
  typedef struct packed {
    logic                valid;
    logic [XLEN_DEF-1:0] pc;
  } pc_stage_t;

  // True when v is a non-zero power of two
  function automatic bit is_pow2(input int unsigned v);
    return (v != 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/pc_delay_stage.sv
// rtl/pc_delay_stage.sv - one valid-tagged PC register with advance and flush
module pc_delay_stage #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            en,
  input  logic            flush,
  input  logic            d_valid,
  input  logic [XLEN-1:0] d_pc,
  output logic            q_valid,
  output logic [XLEN-1:0] q_pc
);

  logic            valid_q, valid_d;
  logic [XLEN-1:0] pc_q, pc_d;

  // Flush only clears the tag; the pc field keeps its last value
  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (en) begin
      valid_d = d_valid;
      pc_d    = d_pc;
    end
  end

  // Stage register with synchronous reset to an empty, zero stage
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
    end
  end

  assign q_valid = valid_q;
  assign q_pc    = pc_q;

endmodule

// File: rtl/pc_pipeline.sv
// rtl/pc_pipeline.sv - fetch PC register, redirect/stall priority and delay chain
module pc_pipeline
  import pc_pkg::*;
#(
  parameter int unsigned XLEN             = XLEN_DEF,
  parameter int unsigned PIPE_DEPTH       = 2,
  parameter int unsigned INCR             = INCR_DEF,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(PC_RESET_VECTOR),
  parameter int unsigned CNT_W            = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             redirect_valid,
  input  logic [XLEN-1:0]  redirect_target,
  output logic [XLEN-1:0]  fetch_pc,
  output logic [XLEN-1:0]  out_pc,
  output logic             out_valid,
  output logic             misalign_err,
  output logic [CNT_W-1:0] retired_count
);

  if (PIPE_DEPTH < 1 || PIPE_DEPTH > 8) begin : g_bad_depth
    $error("pc_pipeline: PIPE_DEPTH must be within 1..8");
  end
  if (!is_pow2(INCR)) begin : g_bad_incr
    $error("pc_pipeline: INCR must be a power of two");
  end
  if ((RESET_VECTOR & XLEN'(INCR - 1)) != '0) begin : g_bad_rv
    $error("pc_pipeline: RESET_VECTOR must be INCR-aligned");
  end

  localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(INCR - 1);

  logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
  logic             misalign_q, misalign_d;
  logic [CNT_W-1:0] retired_q, retired_d;

  logic aligned, redirect_ok, advance;

  // Index 0 is the chain input (the live fetch PC); index PIPE_DEPTH is the output
  logic [PIPE_DEPTH:0] stage_valid;
  logic [XLEN-1:0]     stage_pc [PIPE_DEPTH+1];

  assign stage_valid[0] = 1'b1;
  assign stage_pc[0]    = fetch_pc_q;

  // Priority: aligned redirect, then stall, then advance; a misaligned redirect is dropped
  always_comb begin
    aligned     = (redirect_target & ALIGN_MASK) == '0;
    redirect_ok = redirect_valid && aligned;
    advance     = !redirect_ok && !stall;
    misalign_d  = redirect_valid && !aligned;
    fetch_pc_d  = fetch_pc_q;
    retired_d   = retired_q;
    if (redirect_ok) begin
      fetch_pc_d = redirect_target;
    end else if (advance) begin
      fetch_pc_d = fetch_pc_q + XLEN'(INCR);
      if (stage_valid[PIPE_DEPTH]) begin
        retired_d = retired_q + CNT_W'(1);
      end
    end
  end

  // Fetch PC, error pulse and retire counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q <= RESET_VECTOR;
      misalign_q <= 1'b0;
      retired_q  <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      misalign_q <= misalign_d;
      retired_q  <= retired_d;
    end
  end

  for (genvar i = 0; i < PIPE_DEPTH; i++) begin : g_stage
    pc_delay_stage #(.XLEN(XLEN)) u_stage (
      .clk     (clk),
      .reset   (reset),
      .en      (advance),
      .flush   (redirect_ok),
      .d_valid (stage_valid[i]),
      .d_pc    (stage_pc[i]),
      .q_valid (stage_valid[i+1]),
      .q_pc    (stage_pc[i+1])
    );
  end

  assign fetch_pc      = fetch_pc_q;
  assign out_pc        = stage_pc[PIPE_DEPTH];
  assign out_valid     = stage_valid[PIPE_DEPTH];
  assign misalign_err  = misalign_q;
  assign retired_count = retired_q;

endmodule
